// File: rtl/secuenciador_secciones.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : secuenciador_secciones                                           |
// | Brief   : Quadrant sequencer for the XY painter. Debounced next/prev       |
// |           buttons step the active section, or it auto-advances every       |
// |           FRAMES_PER_STEP frame ticks. Single clock domain (clk2).         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module secuenciador_secciones #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FRAMES_PER_STEP = 60
) (
   input  logic       clk2,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       modo_auto,
   input  logic       apagar,
   input  logic       frame_tick,
   output logic [2:0] seccion_actual,
   output logic [1:0] modo_actual,
   output logic       cambio
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FCW = $clog2(FRAMES_PER_STEP + 1);
   localparam logic [DBW-1:0] C_DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FCW-1:0] C_FC_LAST = FCW'(FRAMES_PER_STEP - 1);

   // State encoding doubles as the modo_actual output code.
   typedef enum logic [1:0] {
      ST_BLANK  = 2'b00,
      ST_MANUAL = 2'b01,
      ST_AUTO   = 2'b10
   } state_t;

   logic [1:0] w_btn_raw;
   logic [1:0] w_pulse;   // [0] = pn (next), [1] = pp (prev)

   assign w_btn_raw = {btn_prev, btn_next};

   // Per-button synchroniser, debouncer and rising-edge detector.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic [1:0]     sync_q;
         logic [DBW-1:0] cnt_q;
         logic           acc_q;
         logic           acc_prev_q;

         // Two-flop synchroniser followed by a consecutive-sample debounce counter.
         always_ff @(posedge clk2) begin
            if (reset) begin
               sync_q     <= 2'b00;
               cnt_q      <= '0;
               acc_q      <= 1'b0;
               acc_prev_q <= 1'b0;
            end else begin
               sync_q     <= {sync_q[0], w_btn_raw[gi]};
               acc_prev_q <= acc_q;
               if (sync_q[1] != acc_q) begin
                  if (cnt_q == C_DB_LAST) begin
                     acc_q <= ~acc_q;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + DBW'(1);
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
         end

         // Accepted-level clears to 0 on reset, so a held button reads as a fresh press.
         assign w_pulse[gi] = acc_q & ~acc_prev_q;
      end
   endgenerate

   function automatic logic [2:0] f_next(input logic [2:0] s);
      return (s == 3'd4) ? 3'd1 : s + 3'd1;
   endfunction

   function automatic logic [2:0] f_prev(input logic [2:0] s);
      return (s == 3'd1) ? 3'd4 : s - 3'd1;
   endfunction

   state_t         state_q, state_d;
   logic [2:0]     seccion_q, seccion_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           cambio_q;
   logic           w_step_n, w_step_p, w_step;

   // Simultaneous next and prev cancel each other out.
   assign w_step_n = w_pulse[0] & ~w_pulse[1];
   assign w_step_p = w_pulse[1] & ~w_pulse[0];
   assign w_step   = w_step_n | w_step_p;

   // Next-state logic: apagar, then buttons, then mode change, then frame ticks.
   always_comb begin
      state_d   = state_q;
      seccion_d = seccion_q;
      fcnt_d    = fcnt_q;
      if (apagar) begin
         state_d   = ST_BLANK;
         seccion_d = 3'd0;
         fcnt_d    = '0;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (w_step_n) begin
                  state_d   = ST_MANUAL;
                  seccion_d = 3'd1;
               end else if (w_step_p) begin
                  state_d   = ST_MANUAL;
                  seccion_d = 3'd4;
               end else if (modo_auto) begin
                  state_d   = ST_AUTO;
                  seccion_d = 3'd1;
                  fcnt_d    = '0;
               end
            end
            ST_MANUAL: begin
               if (w_step_n)      seccion_d = f_next(seccion_q);
               else if (w_step_p) seccion_d = f_prev(seccion_q);
               if (modo_auto) begin
                  state_d = ST_AUTO;
                  fcnt_d  = '0;
               end
            end
            ST_AUTO: begin
               if (w_step_n)      seccion_d = f_next(seccion_q);
               else if (w_step_p) seccion_d = f_prev(seccion_q);
               if (w_step) fcnt_d = '0;
               if (!modo_auto) begin
                  state_d = ST_MANUAL;
                  fcnt_d  = '0;
               end else if (!w_step && frame_tick) begin
                  if (fcnt_q == C_FC_LAST) begin
                     seccion_d = f_next(seccion_q);
                     fcnt_d    = '0;
                  end else begin
                     fcnt_d = fcnt_q + FCW'(1);
                  end
               end
            end
            default: begin
               state_d   = ST_BLANK;
               seccion_d = 3'd0;
               fcnt_d    = '0;
            end
         endcase
      end
   end

   // State, section, frame counter and change-pulse registers.
   always_ff @(posedge clk2) begin
      if (reset) begin
         state_q   <= ST_BLANK;
         seccion_q <= 3'd0;
         fcnt_q    <= '0;
         cambio_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         seccion_q <= seccion_d;
         fcnt_q    <= fcnt_d;
         cambio_q  <= (seccion_d != seccion_q);
      end
   end

   assign seccion_actual = seccion_q;
   assign modo_actual    = state_q;
   assign cambio         = cambio_q;

endmodule
`default_nettype wire
